// File: rtl/serial_shift_rotate_unit_pkg.sv
// Shared constants and types for the sequential shift/rotate unit.
// The combinational decoder uses the same opcode constants.
package shift_rotate_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AMT_W = 5;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned B_W   = OP_W + AMT_W;

    typedef enum logic [OP_W-1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Control word layout on B: {op, amount}
    typedef struct packed {
        op_e              op;
        logic [AMT_W-1:0] amt;
    } ctrl_t;

endpackage

// File: rtl/serial_shift_rotate_unit_if.sv
// Request/response handshake bundle between requester and the shift/rotate unit.
interface serial_shift_rotate_unit_if;
    import shift_rotate_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [B_W-1:0]   B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic             carry;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, C, carry
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, C, carry
    );

endinterface

// File: rtl/serial_shift_rotate_unit_shift_step.sv
// One single-bit shift or rotate step; out bit is the bit leaving the word.
module shift_step
    import shift_rotate_pkg::*;
(
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_next_data_c,
    output logic             o_out_bit_c
);

    always_comb begin
        o_next_data_c = i_data;
        o_out_bit_c   = 1'b0;
        unique case (i_op)
            OP_LSL: begin
                o_out_bit_c   = i_data[WIDTH-1];
                o_next_data_c = {i_data[WIDTH-2:0], 1'b0};
            end
            OP_LSR: begin
                o_out_bit_c   = i_data[0];
                o_next_data_c = {1'b0, i_data[WIDTH-1:1]};
            end
            OP_ASR: begin
                o_out_bit_c   = i_data[0];
                o_next_data_c = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            end
            OP_ROR: begin
                o_out_bit_c   = i_data[0];
                o_next_data_c = {i_data[0], i_data[WIDTH-1:1]};
            end
        endcase
    end

endmodule

// File: rtl/serial_shift_rotate_unit.sv
// Sequential shift/rotate responder: accepts A/B, performs one bit step per clock,
// and returns C/carry over a valid/ready handshake.
module serial_shift_rotate_unit
    import shift_rotate_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    serial_shift_rotate_unit_if.slave  bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_c;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    ctrl_t            w_ctrl;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_bit;

    assign w_ctrl = ctrl_t'(bus.B);

    shift_step u_shift_step (
        .i_op          (r_op),
        .i_data        (r_c),
        .o_next_data_c (w_step_data),
        .o_out_bit_c   (w_step_bit)
    );

    // State, handshake flags and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_op        <= OP_LSL;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_c     <= bus.A;
                        r_carry <= 1'b0;
                        r_op    <= w_ctrl.op;
                        r_cnt   <= w_ctrl.amt;
                    end
                end
                SHIFT: begin
                    r_c     <= w_step_data;
                    r_carry <= w_step_bit;
                    r_cnt   <= r_cnt - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = (w_ctrl.amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the upcoming state decode
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.C         = r_c;
    assign bus.carry     = r_carry;

endmodule

// File: tb/tb_serial_shift_rotate_unit.sv
// Self-checking bench for serial_shift_rotate_unit with a behavioural shift/rotate model.
module tb_serial_shift_rotate_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_shift_rotate_unit_if u_if ();

    serial_shift_rotate_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-word reference: N-bit shift/rotate computed in one go
    function automatic void ref_model(input logic [31:0] a, input logic [6:0] b,
                                      output logic [31:0] c, output logic cy);
        int n;
        logic [1:0] op;
        n  = int'(b[4:0]);
        op = b[6:5];
        c  = a;
        cy = 1'b0;
        if (n != 0) begin
            case (op)
                2'b00: begin c = a << n; cy = a[32-n]; end
                2'b01: begin c = a >> n; cy = a[n-1]; end
                2'b10: begin c = 32'($signed(a) >>> n); cy = a[n-1]; end
                default: begin c = (a >> n) | (a << (32 - n)); cy = c[31]; end
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for the result; lat counts edges including the accepting one
    task automatic run_op(input logic [31:0] a, input logic [6:0] b,
                          output logic [31:0] c, output logic cy, output int lat, output bit to);
        int w;
        u_if.A         = a;
        u_if.B         = b;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b0;
        w = 0;
        while (!u_if.in_ready && w < 200) begin
            tick();
            w++;
        end
        tick();
        u_if.in_valid = 1'b0;
        lat = 1;
        while (!u_if.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        to = !u_if.out_valid;
        c  = u_if.C;
        cy = u_if.carry;
    endtask

    task automatic release_result();
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] c;
        logic cy;
        int lat;
        bit to;
        checks++;
        if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.C !== 32'h0 || u_if.carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: rdy=%b vld=%b C=%h carry=%b, need 1 0 00000000 0",
                     u_if.in_ready, u_if.out_valid, u_if.C, u_if.carry);
        end
        // Start a long LSL, then reset mid-SHIFT
        u_if.A = 32'hFFFF_FFFF;
        u_if.B = 7'b00_11111;
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (u_if.in_ready !== 1'b0 || u_if.C === 32'h0) begin
            errors++;
            $display("FAIL reset_midshift_busy: rdy=%b C=%h, need busy with nonzero C", u_if.in_ready, u_if.C);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.C !== 32'h0 || u_if.carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_midshift: rdy=%b vld=%b C=%h carry=%b, need 1 0 00000000 0",
                     u_if.in_ready, u_if.out_valid, u_if.C, u_if.carry);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.C !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_idle: rdy=%b vld=%b C=%h, need 1 0 00000000",
                     u_if.in_ready, u_if.out_valid, u_if.C);
        end
        // Partial result discarded: a fresh N=0 request returns its own operand
        run_op(32'h1234_5678, 7'b00_00000, c, cy, lat, to);
        checks++;
        if (to || c !== 32'h1234_5678 || cy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_op: C=%h carry=%b timeout=%b, need 12345678 0 0", c, cy, to);
        end
        release_result();
    endtask

    task automatic test_directed(input string name, input logic [31:0] a, input logic [6:0] b,
                                 input logic [31:0] exp_c, input logic exp_cy, input int exp_lat);
        logic [31:0] c;
        logic cy;
        int lat;
        bit to;
        run_op(a, b, c, cy, lat, to);
        checks++;
        if (to || c !== exp_c || cy !== exp_cy) begin
            errors++;
            $display("FAIL %s_result: C=%h carry=%b timeout=%b, need %h %b", name, c, cy, to, exp_c, exp_cy);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, need %0d", name, lat, exp_lat);
        end
        release_result();
        checks++;
        if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_return_idle: rdy=%b vld=%b, need 1 0", name, u_if.in_ready, u_if.out_valid);
        end
    endtask

    task automatic test_n0_backpressure();
        logic [31:0] c;
        logic cy;
        int lat;
        bit to;
        run_op(32'hDEAD_BEEF, 7'b01_00000, c, cy, lat, to);
        checks++;
        if (to || c !== 32'hDEAD_BEEF || cy !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL n0_result: C=%h carry=%b lat=%0d, need deadbeef 0 1", c, cy, lat);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0 || u_if.C !== 32'hDEAD_BEEF || u_if.carry !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: vld=%b rdy=%b C=%h carry=%b, need 1 0 deadbeef 0",
                         i, u_if.out_valid, u_if.in_ready, u_if.C, u_if.carry);
            end
        end
        release_result();
        checks++;
        if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: rdy=%b vld=%b, need 1 0", u_if.in_ready, u_if.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c;
        logic cy;
        logic [31:0] exp_c;
        logic exp_cy;
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [6:0] b;
            a = $urandom;
            b = 7'($urandom_range(0, 127));
            ref_model(a, b, exp_c, exp_cy);
            run_op(a, b, c, cy, lat, to);
            checks++;
            if (to || c !== exp_c || cy !== exp_cy) begin
                errors++;
                $display("FAIL b2b_%0d: C=%h carry=%b, need %h %b", i, c, cy, exp_c, exp_cy);
            end
            // Result taken on this edge; the unit must be ready right after it
            release_result();
            checks++;
            if (u_if.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: rdy=%b, need 1", i, u_if.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        logic cy;
        logic [31:0] exp_c;
        logic exp_cy;
        int lat;
        bit to;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] a;
            logic [6:0] b;
            int hold;
            a    = $urandom;
            b    = 7'($urandom_range(0, 127));
            hold = int'($urandom_range(0, 2));
            ref_model(a, b, exp_c, exp_cy);
            run_op(a, b, c, cy, lat, to);
            checks++;
            if (to || c !== exp_c || cy !== exp_cy || lat !== int'(b[4:0]) + 1) begin
                errors++;
                $display("FAIL random_%0d: A=%h B=%b C=%h carry=%b lat=%0d, need %h %b %0d",
                         i, a, b, c, cy, lat, exp_c, exp_cy, int'(b[4:0]) + 1);
            end
            repeat (hold) tick();
            release_result();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        u_if.A         = '0;
        u_if.B         = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        test_reset();
        test_directed("lsl", 32'h8000_0001, 7'b00_00001, 32'h0000_0002, 1'b1, 2);
        test_directed("asr", 32'hF000_0000, 7'b10_00100, 32'hFF00_0000, 1'b0, 5);
        test_directed("ror31", 32'h0000_0001, 7'b11_11111, 32'h0000_0002, 1'b0, 32);
        test_directed("ror1", 32'h0000_0001, 7'b11_00001, 32'h8000_0000, 1'b1, 2);
        test_directed("lsr31", 32'h8000_0000, 7'b01_11111, 32'h0000_0001, 1'b0, 32);
        test_n0_backpressure();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
